ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte, such as the keyboard LED command 0xED or mouse init 0xF4, to a PS/2 device over the shared open-drain clock and data lines. It is the opposite direction to the keyboard/mouse receivers and runs in the clock32 domain. Open-drain drive is exposed as separate enable outputs; the top level builds the tristate pins from them.

---
 rtl/ps2_host_tx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
// The module drives the open-drain clock and data lines through separate
// pull-low enables. The top level combines these enables with the pins.
module ps2_host_tx #(
  parameter int INH = 3200,
  parameter int TMO = 480000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ckI,
  input  logic       dqI,
  output logic       ckOe,
  output logic       dqOe
);

  localparam int IW = (INH > 1) ? $clog2(INH) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAITUP
  } state_t;

  // Pin conditioning: synchronizer flops, sample history and filtered levels
  logic [1:0] ckSync_q, dqSync_q;
  logic [2:0] ckHist_q, dqHist_q;
  logic       ckFilt_q, dqFilt_q;
  logic       fall_q;

  // Each window holds the newest synchronized sample plus the three before it
  logic [3:0] ckWin_d, dqWin_d;
  assign ckWin_d = {ckHist_q, ckSync_q[1]};
  assign dqWin_d = {dqHist_q, dqSync_q[1]};

  // Transfer state
  state_t      state_q;
  logic [IW-1:0] inhCnt_q;
  logic [TW-1:0] tmoCnt_q;
  logic [3:0]  bitCnt_q;
  logic [9:0]  shift_q;
  logic        busy_q, done_q, err_q, ckOe_q, dqOe_q;

  logic tmoHit_d;
  logic par_d;
  assign tmoHit_d = (tmoCnt_q == TW'(TMO - 1));
  assign par_d    = ~^data;

  // Synchronize both pins. A filtered level changes only after four equal samples in a row.
  always_ff @(posedge clock) begin
    if (reset) begin
      ckSync_q <= 2'b11;
      dqSync_q <= 2'b11;
      ckHist_q <= 3'b111;
      dqHist_q <= 3'b111;
      ckFilt_q <= 1'b1;
      dqFilt_q <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      ckSync_q <= {ckSync_q[0], ckI};
      dqSync_q <= {dqSync_q[0], dqI};
      ckHist_q <= ckWin_d[2:0];
      dqHist_q <= dqWin_d[2:0];
      if (ckWin_d == 4'b0000) begin
        ckFilt_q <= 1'b0;
      end else if (ckWin_d == 4'b1111) begin
        ckFilt_q <= 1'b1;
      end
      if (dqWin_d == 4'b0000) begin
        dqFilt_q <= 1'b0;
      end else if (dqWin_d == 4'b1111) begin
        dqFilt_q <= 1'b1;
      end
      fall_q <= ckFilt_q && (ckWin_d == 4'b0000);
    end
  end

  // Frame sequencer: inhibit, request-to-send, ten data/parity/stop bits, ack, then line release
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      inhCnt_q <= '0;
      tmoCnt_q <= '0;
      bitCnt_q <= 4'd0;
      shift_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ckOe_q   <= 1'b0;
      dqOe_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          ckOe_q <= 1'b0;
          dqOe_q <= 1'b0;
          if (strb && !done_q && !err_q) begin
            shift_q  <= {1'b1, par_d, data};
            busy_q   <= 1'b1;
            ckOe_q   <= 1'b1;
            inhCnt_q <= '0;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inhCnt_q == IW'(INH - 1)) begin
            ckOe_q   <= 1'b0;
            dqOe_q   <= 1'b1;
            bitCnt_q <= 4'd0;
            tmoCnt_q <= '0;
            state_q  <= RTS;
          end else begin
            inhCnt_q <= inhCnt_q + IW'(1);
          end
        end
        default: begin
          if (tmoHit_d) begin
            ckOe_q  <= 1'b0;
            dqOe_q  <= 1'b0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmoCnt_q <= tmoCnt_q + TW'(1);
            case (state_q)
              RTS: begin
                bitCnt_q <= 4'd0;
                state_q  <= SEND;
              end
              SEND: begin
                if (fall_q) begin
                  dqOe_q   <= ~shift_q[0];
                  shift_q  <= {1'b1, shift_q[9:1]};
                  bitCnt_q <= bitCnt_q + 4'd1;
                  if (bitCnt_q == 4'd9) begin
                    state_q <= ACK;
                  end
                end
              end
              ACK: begin
                if (fall_q) begin
                  if (!dqFilt_q) begin
                    state_q <= WAITUP;
                  end else begin
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    ckOe_q  <= 1'b0;
                    dqOe_q  <= 1'b0;
                    state_q <= IDLE;
                  end
                end
              end
              WAITUP: begin
                if (ckFilt_q && dqFilt_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end
              end
              default: begin
                state_q <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign ckOe = ckOe_q;
  assign dqOe = dqOe_q;

endmodule
